// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record kinds, the trace record
// layout, the buffer FSM states and the commit classifier.
package trace_pkg;

    // Width of the instruction index stored inside each record.
    localparam int TRACE_CNT_W = 32;

    typedef enum logic [2:0] {
        KIND_REG   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_STORE = 3'd2,
        KIND_OTHER = 3'd3,
        KIND_HALT  = 3'd4
    } rec_kind_e;

    typedef struct packed {
        rec_kind_e               kind;
        logic [TRACE_CNT_W-1:0]  inum;
        logic [15:0]             pc;
        logic [15:0]             a;
        logic [15:0]             b;
        logic [15:0]             addr;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_e;

    // A regfile write always wins (load vs. ALU op), then halt, then store.
    function automatic rec_kind_e classify(input logic reg_write,
                                           input logic mem_read,
                                           input logic mem_write,
                                           input logic halt);
        rec_kind_e kind;
        if (reg_write) begin
            if (mem_read) kind = KIND_LOAD;
            else          kind = KIND_REG;
        end else if (halt) begin
            kind = KIND_HALT;
        end else if (mem_write) begin
            kind = KIND_STORE;
        end else begin
            kind = KIND_OTHER;
        end
        return kind;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records. The last free slot is held back for a
// record flagged i_reserved (the HALT record), so a halt is never lost even
// when ordinary records are being dropped. The head entry is read
// combinationally so a record pushed into an empty FIFO is visible right
// after the push edge.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_reserved,
    input  trace_rec_t                 i_data,
    input  logic                       i_pop,
    output trace_rec_t                 o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_accept,
    output logic                       o_pop_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LAST_FREE = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);

    trace_rec_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_pop;
    logic               w_accept;

    // Ordinary records may only fill up to DEPTH-1 entries unless a pop frees
    // a slot on the same edge; reserved records may take the final slot.
    always_comb begin
        w_pop    = i_pop && (r_count != '0);
        w_accept = i_push && (w_pop || (r_count < LAST_FREE) ||
                              (i_reserved && (r_count < FULL_CNT)));
    end

    // Record storage; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_accept   = w_accept;
    assign o_pop_done = w_pop;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer for the 16-bit single-cycle cpu. Every edge in RUN
// retires one instruction: it is classified, numbered and queued as a trace
// record that drains over a valid/ready stream. A HALT record moves the FSM
// to DRAIN, and once the queue empties the block sits in DONE until reset.
// Build option: define TRACE_SKIP_OTHER_EN to count but not queue
// branch/NOP (OTHER) instructions.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = TRACE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       c_pc,
    input  logic [15:0]       c_inst,
    input  logic              c_reg_write,
    input  logic [3:0]        c_wr_reg,
    input  logic [15:0]       c_wr_data,
    input  logic              c_mem_read,
    input  logic              c_mem_write,
    input  logic [15:0]       c_mem_addr,
    input  logic [15:0]       c_mem_data,
    input  logic              c_halt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_kind,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [15:0]       rec_pc,
    output logic [15:0]       rec_a,
    output logic [15:0]       rec_b,
    output logic [15:0]       rec_addr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic              overflow,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_state_e       r_state;
    trace_state_e       w_state_next;
    logic               w_done;

    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   r_inst_count;
    logic               r_overflow;

    rec_kind_e          w_kind;
    trace_rec_t         w_rec;
    trace_rec_t         w_head;
    logic               w_retire;
    logic               w_push;
    logic               w_is_halt;
    logic               w_pop;
    logic               w_accept;
    logic               w_pop_done;
    logic               w_empty;
    logic               w_valid;
    logic [PTR_W:0]     w_count;

    // The instruction word is not part of the record.
    logic               w_unused_inst;
    assign w_unused_inst = ^c_inst;

    // Classify the committing instruction and assemble its record.
    always_comb begin
        w_kind    = classify(c_reg_write, c_mem_read, c_mem_write, c_halt);
        w_is_halt = (w_kind == KIND_HALT);
        w_rec      = '0;
        w_rec.kind = w_kind;
        w_rec.inum = TRACE_CNT_W'(r_inst_count);
        w_rec.pc   = c_pc;
        case (w_kind)
            KIND_REG: begin
                w_rec.a = {12'b0, c_wr_reg};
                w_rec.b = c_wr_data;
            end
            KIND_LOAD: begin
                w_rec.a    = {12'b0, c_wr_reg};
                w_rec.b    = c_wr_data;
                w_rec.addr = c_mem_addr;
            end
            KIND_STORE: begin
                w_rec.a = c_mem_addr;
                w_rec.b = c_mem_data;
            end
            default: begin
                w_rec.a = '0;
            end
        endcase
    end

    // Only RUN retires instructions; OTHER may be filtered out of the queue.
    always_comb begin
        w_retire = (r_state == ST_RUN);
`ifdef TRACE_SKIP_OTHER_EN
        w_push   = w_retire && (w_kind != KIND_OTHER);
`else
        w_push   = w_retire;
`endif
        w_valid  = !w_empty && (r_state != ST_DONE);
        w_pop    = w_valid && rec_ready;
    end

    trace_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_reserved (w_is_halt),
        .i_data     (w_rec),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_accept   (w_accept),
        .o_pop_done (w_pop_done)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    // FSM next state: halt queued -> drain; last record popped -> done.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_push && w_is_halt && w_accept) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop_done && (w_count == (PTR_W+1)'(1))) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Saturating counters and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
            r_inst_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if ((r_state != ST_DONE) && (r_cycle_count != '1))
                r_cycle_count <= r_cycle_count + 1'b1;
            if (w_retire && (r_inst_count != '1))
                r_inst_count <= r_inst_count + 1'b1;
            if (w_push && !w_accept)
                r_overflow <= 1'b1;
        end
    end

    // Record outputs read as zero whenever no record is being offered.
    always_comb begin
        rec_valid = w_valid;
        rec_kind  = w_valid ? w_head.kind : 3'd0;
        rec_inum  = w_valid ? CNT_W'(w_head.inum) : '0;
        rec_pc    = w_valid ? w_head.pc   : 16'h0000;
        rec_a     = w_valid ? w_head.a    : 16'h0000;
        rec_b     = w_valid ? w_head.b    : 16'h0000;
        rec_addr  = w_valid ? w_head.addr : 16'h0000;
    end

    assign cycle_count = r_cycle_count;
    assign inst_count  = r_inst_count;
    assign overflow    = r_overflow;
    assign done        = w_done;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=16, CNT_W=32).
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       c_pc;
    logic [15:0]       c_inst;
    logic              c_reg_write;
    logic [3:0]        c_wr_reg;
    logic [15:0]       c_wr_data;
    logic              c_mem_read;
    logic              c_mem_write;
    logic [15:0]       c_mem_addr;
    logic [15:0]       c_mem_data;
    logic              c_halt;
    logic              rec_valid;
    logic              rec_ready;
    logic [2:0]        rec_kind;
    logic [CNT_W-1:0]  rec_inum;
    logic [15:0]       rec_pc;
    logic [15:0]       rec_a;
    logic [15:0]       rec_b;
    logic [15:0]       rec_addr;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  inst_count;
    logic              overflow;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_pc        (c_pc),
        .c_inst      (c_inst),
        .c_reg_write (c_reg_write),
        .c_wr_reg    (c_wr_reg),
        .c_wr_data   (c_wr_data),
        .c_mem_read  (c_mem_read),
        .c_mem_write (c_mem_write),
        .c_mem_addr  (c_mem_addr),
        .c_mem_data  (c_mem_data),
        .c_halt      (c_halt),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_kind    (rec_kind),
        .rec_inum    (rec_inum),
        .rec_pc      (rec_pc),
        .rec_a       (rec_a),
        .rec_b       (rec_b),
        .rec_addr    (rec_addr),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .overflow    (overflow),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %s observed=0x%0h ok", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_c();
        c_pc = 16'h0; c_inst = 16'h0; c_reg_write = 1'b0; c_wr_reg = 4'h0;
        c_wr_data = 16'h0; c_mem_read = 1'b0; c_mem_write = 1'b0;
        c_mem_addr = 16'h0; c_mem_data = 16'h0; c_halt = 1'b0;
    endtask

    task automatic set_add(input logic [15:0] pc, input logic [3:0] rd, input logic [15:0] data);
        clear_c();
        c_pc = pc; c_inst = 16'h1000; c_reg_write = 1'b1; c_wr_reg = rd; c_wr_data = data;
    endtask

    task automatic set_halt(input logic [15:0] pc);
        clear_c();
        c_pc = pc; c_inst = 16'hF000; c_halt = 1'b1;
    endtask

    // Leaves rst_n low; caller loads the first commit and releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        rec_ready = 1'b0;
        clear_c();
        step();
        step();
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_valid", rec_valid, 0);
        chk("rst_kind", rec_kind, 0);
        chk("rst_b", rec_b, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_inst", inst_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);

        // ---- single ADD, visible the cycle after the push ----
        set_add(16'h0000, 4'd3, 16'h0042);
        rec_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("add_valid", rec_valid, 1);
        chk("add_kind", rec_kind, 0);
        chk("add_inum", rec_inum, 0);
        chk("add_a", rec_a, 16'h0003);
        chk("add_b", rec_b, 16'h0042);
        chk("add_addr", rec_addr, 0);
        chk("add_inst", inst_count, 1);
        chk("add_cycle", cycle_count, 1);

        // ---- LW then SW ----
        do_reset();
        clear_c();
        c_pc = 16'h0002; c_reg_write = 1'b1; c_mem_read = 1'b1; c_wr_reg = 4'd5;
        c_wr_data = 16'h1234; c_mem_addr = 16'h0100;
        rec_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("lw_kind", rec_kind, 1);
        chk("lw_inum", rec_inum, 0);
        chk("lw_addr", rec_addr, 16'h0100);
        chk("lw_a", rec_a, 16'h0005);
        chk("lw_b", rec_b, 16'h1234);
        clear_c();
        c_pc = 16'h0004; c_mem_write = 1'b1; c_mem_addr = 16'h0102; c_mem_data = 16'hBEEF;
        step();
        chk("sw_valid", rec_valid, 1);
        chk("sw_kind", rec_kind, 2);
        chk("sw_inum", rec_inum, 1);
        chk("sw_a", rec_a, 16'h0102);
        chk("sw_b", rec_b, 16'hBEEF);
        chk("sw_addr", rec_addr, 0);
        chk("sw_pc", rec_pc, 16'h0004);

        // ---- fill with ready low: 15 kept, 16th dropped, then HLT takes the reserved slot ----
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_add(16'(2 * i), 4'(i), 16'(16'h1000 + i));
            step();
            if (i == 14) chk("fill15_ovf", overflow, 0);
            if (i == 15) chk("fill16_ovf", overflow, 1);
        end
        chk("fill_inst", inst_count, 20);
        chk("fill_head_inum", rec_inum, 0);
        chk("fill_head_b", rec_b, 16'h1000);
        set_halt(16'h0028);
        step();
        chk("hlt_inst", inst_count, 21);
        chk("hlt_head_inum", rec_inum, 0);
        chk("hlt_done", done, 0);
        // commits presented during the drain must be ignored
        set_add(16'h0100, 4'd9, 16'hDEAD);
        rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", rec_valid, 1);
            if (k < 15) begin
                chk("drain_inum", rec_inum, 64'(k));
                chk("drain_kind", rec_kind, 0);
                chk("drain_b", rec_b, 64'(16'h1000 + k));
            end else begin
                chk("drain_halt_kind", rec_kind, 4);
                chk("drain_halt_inum", rec_inum, 20);
                chk("drain_halt_pc", rec_pc, 16'h0028);
                chk("drain_halt_a", rec_a, 0);
            end
            step();
        end
        chk("done_flag", done, 1);
        chk("done_valid", rec_valid, 0);
        chk("done_inst", inst_count, 21);
        chk("done_cycle", cycle_count, 37);
        chk("done_ovf", overflow, 1);
        step();
        step();
        chk("frozen_cycle", cycle_count, 37);
        chk("frozen_inst", inst_count, 21);
        chk("frozen_done", done, 1);
        chk("frozen_valid", rec_valid, 0);

        // ---- branch commit (all strobes low) ----
        do_reset();
        clear_c();
        c_pc = 16'h0010; c_inst = 16'hC004;
        rec_ready = 1'b1;
        rst_n = 1'b1;
        step();
`ifdef TRACE_SKIP_OTHER_EN
        chk("br_valid", rec_valid, 0);
`else
        chk("br_valid", rec_valid, 1);
        chk("br_kind", rec_kind, 3);
        chk("br_inum", rec_inum, 0);
        chk("br_pc", rec_pc, 16'h0010);
        chk("br_a", rec_a, 0);
        chk("br_b", rec_b, 0);
`endif
        chk("br_inst", inst_count, 1);
        set_add(16'h0012, 4'd7, 16'h0077);
        step();
        chk("br_next_kind", rec_kind, 0);
        chk("br_next_inum", rec_inum, 1);
        chk("br_next_b", rec_b, 16'h0077);

        // ---- reset while draining with 5 records queued ----
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_add(16'(2 * i), 4'(i + 1), 16'(16'h2000 + i));
            step();
        end
        set_halt(16'h0008);
        step();
        step();
        chk("dr_valid", rec_valid, 1);
        chk("dr_inst", inst_count, 5);
        chk("dr_cycle", cycle_count, 6);
        chk("dr_head", rec_b, 16'h2000);
        rst_n = 1'b0;
        step();
        chk("dr_rst_valid", rec_valid, 0);
        chk("dr_rst_cycle", cycle_count, 0);
        chk("dr_rst_inst", inst_count, 0);
        chk("dr_rst_done", done, 0);
        chk("dr_rst_kind", rec_kind, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
